// File: rtl/buf_drain.sv
// Row buffer that drains whole rows as a stream of memory-width words, each tagged {row, word_id}.
// Optional write-hazard detector enabled by defining BUF_DRAIN_HAZARD_CHK_EN.
//
// state | meaning
// IDLE  | waiting for start
// READ  | row read issued, data valid next cycle
// SEND  | presenting words of the current row
// FIN   | one-cycle done pulse
module buf_drain #(
   parameter int MEM_DATA_WIDTH = 64,
   parameter int ARRAY_M        = 64,
   parameter int DATA_WIDTH     = 16,
   parameter int BUF_ADDR_WIDTH = 9,
   localparam int GROUP_SIZE    = ARRAY_M * DATA_WIDTH / MEM_DATA_WIDTH,
   localparam int GROUP_ID_W    = (GROUP_SIZE == 1) ? 0 : $clog2(GROUP_SIZE),
   localparam int ROW_W         = ARRAY_M * DATA_WIDTH
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 buf_write_req,
   input  logic [BUF_ADDR_WIDTH-1:0]            buf_write_addr,
   input  logic [ROW_W-1:0]                     buf_write_data,
   input  logic                                 start,
   input  logic [BUF_ADDR_WIDTH-1:0]            start_addr,
   input  logic [BUF_ADDR_WIDTH:0]              num_rows,
   output logic                                 busy,
   output logic                                 done,
   output logic                                 m_valid,
   input  logic                                 m_ready,
   output logic [MEM_DATA_WIDTH-1:0]            m_data,
   output logic [BUF_ADDR_WIDTH+GROUP_ID_W-1:0] m_addr,
   output logic                                 m_last
`ifdef BUF_DRAIN_HAZARD_CHK_EN
   ,
   output logic                                 hazard
`endif
);

   localparam int DEPTH = 1 << BUF_ADDR_WIDTH;
   localparam int WID_W = (GROUP_ID_W == 0) ? 1 : GROUP_ID_W;
   localparam logic [WID_W-1:0] LAST_WORD = WID_W'(GROUP_SIZE - 1);
   localparam logic [BUF_ADDR_WIDTH:0] ONE_ROW = (BUF_ADDR_WIDTH + 1)'(1);

   typedef enum logic [1:0] {IDLE, READ, SEND, FIN} state_t;

   state_t                                 state, state_nxt;
   logic [BUF_ADDR_WIDTH-1:0]              row;
   logic [BUF_ADDR_WIDTH:0]                remaining;
   logic [WID_W-1:0]                       word_id;
   logic [ROW_W-1:0]                       mem [DEPTH];
   logic [ROW_W-1:0]                       row_q;
   logic [BUF_ADDR_WIDTH+GROUP_ID_W-1:0]   addr_full;
   logic                                   rd_en, accept, fire, row_end, final_row;

   // Storage is deliberately not reset so it maps onto a RAM; old data wins on a same-row collision.
   always_ff @(posedge clk) begin
      if (buf_write_req) mem[buf_write_addr] <= buf_write_data;
      if (rd_en) row_q <= mem[row];
   end

   assign row_end   = (word_id == LAST_WORD);
   assign final_row = (remaining == ONE_ROW);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      rd_en     = 1'b0;
      accept    = 1'b0;
      fire      = 1'b0;
      busy      = 1'b1;
      done      = 1'b0;
      m_valid   = 1'b0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (start) begin
               accept    = 1'b1;
               state_nxt = (num_rows == '0) ? FIN : READ;
            end
         end
         READ: begin
            rd_en     = 1'b1;
            state_nxt = SEND;
         end
         SEND: begin
            m_valid = 1'b1;
            if (m_ready) begin
               fire = 1'b1;
               if (row_end) state_nxt = final_row ? FIN : READ;
            end
         end
         FIN: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row       <= '0;
         remaining <= '0;
         word_id   <= '0;
      end else begin
         if (accept) begin
            row       <= start_addr;
            remaining <= num_rows;
         end
         if (rd_en) begin
            word_id <= '0;
         end else if (fire) begin
            word_id <= row_end ? '0 : word_id + WID_W'(1);
            if (row_end) begin
               row       <= row + BUF_ADDR_WIDTH'(1);
               remaining <= remaining - ONE_ROW;
            end
         end
      end
   end

   generate
      if (GROUP_ID_W == 0) begin : g_addr_row
         assign addr_full = row;
      end else begin : g_addr_word
         assign addr_full = {row, word_id};
      end
   endgenerate

   // Word outputs are gated to zero outside SEND so reset and idle present a clean bus.
   assign m_data = m_valid ? row_q[int'(word_id)*MEM_DATA_WIDTH +: MEM_DATA_WIDTH] : '0;
   assign m_addr = m_valid ? addr_full : '0;
   assign m_last = m_valid && row_end && final_row;

`ifdef BUF_DRAIN_HAZARD_CHK_EN
   logic [BUF_ADDR_WIDTH-1:0] offset;
   logic                      hit;

   // Rows still owed to the stream are row .. row+remaining-1, modulo buffer depth.
   assign offset = buf_write_addr - row;
   assign hit    = buf_write_req && ((state == READ) || (state == SEND)) &&
                   ({1'b0, offset} < remaining);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      hazard <= 1'b0;
      else if (accept) hazard <= 1'b0;
      else if (hit)    hazard <= 1'b1;
   end
`endif

endmodule

// File: doc/buf_drain.md
BUF_DRAIN -- requirements
Module: buf_drain

Interface
REQ-001 Parameter MEM_DATA_WIDTH, default 64: memory-side word width.
REQ-002 Parameter ARRAY_M, default 64: elements per array row.
REQ-003 Parameter DATA_WIDTH, default 16: element width.
REQ-004 Parameter BUF_ADDR_WIDTH, default 9: row address width; depth 2^BUF_ADDR_WIDTH.
REQ-005 Derived GROUP_SIZE = ARRAY_M*DATA_WIDTH/MEM_DATA_WIDTH (16); GROUP_ID_W = 0 if GROUP_SIZE==1 else clog2(GROUP_SIZE); ROW_W = ARRAY_M*DATA_WIDTH.
REQ-006 One clock; reset is asynchronous and active-low: clk  in  1  clock; reset  in  1  asynchronous active-low reset.
REQ-007 buf_write_req  in  1  array-side row write strobe.
REQ-008 buf_write_addr  in  BUF_ADDR_WIDTH  row write address.
REQ-009 buf_write_data  in  ROW_W  full row data.
REQ-010 start  in  1  drain command strobe.
REQ-011 start_addr  in  BUF_ADDR_WIDTH  first row to drain.
REQ-012 num_rows  in  BUF_ADDR_WIDTH+1  row count, 0..2^BUF_ADDR_WIDTH.
REQ-013 busy  out  1  drain in progress.
REQ-014 done  out  1  one-cycle completion pulse.
REQ-015 m_valid / m_ready  out / in  1 / 1  memory-side stream handshake.
REQ-016 m_data  out  MEM_DATA_WIDTH  word data.
REQ-017 m_addr  out  BUF_ADDR_WIDTH+GROUP_ID_W  word address {row, word_id}.
REQ-018 m_last  out  1  high on final word of the command.

Function
REQ-019 Storage: 2^BUF_ADDR_WIDTH rows of ROW_W; buf_write_req writes whole row at buf_write_addr on the clock edge, at any time, including during a drain.
REQ-020 Row read is synchronous, 1-cycle latency; same-cycle write and read of one row returns old data.
REQ-021 FSM states IDLE, READ, SEND, FIN; reset state IDLE.
REQ-022 IDLE: start=1 latches start_addr/num_rows; num_rows==0 -> FIN, else -> READ; start outside IDLE ignored.
REQ-023 READ: issue row read at current row, word_id=0, -> SEND next cycle.
REQ-024 SEND: m_valid=1; m_data = row bits [word_id*MEM_DATA_WIDTH +: MEM_DATA_WIDTH]; m_addr = {row, word_id}.
REQ-025 m_valid, m_data, m_addr, m_last held stable while m_valid && !m_ready.
REQ-026 On handshake: word_id+1; after word GROUP_SIZE-1, row+1 (wraps modulo 2^BUF_ADDR_WIDTH), remaining-1; remaining 0 -> FIN, else -> READ.
REQ-027 m_last = 1 only on word GROUP_SIZE-1 of final row.
REQ-028 FIN: done=1 for exactly one cycle, -> IDLE; a start in the FIN cycle is ignored.
REQ-029 busy = 1 in READ, SEND, FIN.
REQ-030 Latency: start at cycle t -> first m_valid at t+2; with m_ready held 1, each row takes GROUP_SIZE+1 cycles.

Reset
REQ-031 reset low asynchronously forces IDLE, word_id=0, and busy, done, m_valid, m_last, m_data, m_addr to 0; storage contents are not reset.
REQ-032 reset asserted mid-drain abandons the command; no done pulse; next start after reset release is accepted normally.

Configuration
REQ-033 Macro BUF_DRAIN_HAZARD_CHK_EN defined: extra output hazard (1 bit), sticky, set when buf_write_req targets a row inside the unfinished portion of the active command, cleared by reset or accepted start.
REQ-034 Macro absent: no hazard port, no check logic; all other behaviour identical.

Verification
REQ-035 Write row 5 with word g = 64'h1000+g; start_addr=5, num_rows=1, m_ready=1 -> 16 words 0x1000..0x100F, m_addr 0x050..0x05F, m_last on 0x05F, done at t+18.
REQ-036 start_addr=511, num_rows=2 -> rows 511 then 0; m_addr 0x1FF0..0x1FFF then 0x000..0x00F.
REQ-037 m_ready toggled 1/0 each cycle -> no word dropped or duplicated, outputs stable during stalls, 16 words in order.
REQ-038 num_rows=0 -> no m_valid, done at t+1; start pulsed while busy -> ignored, single done.
REQ-039 reset asserted during word 7 of row 5 -> all outputs 0 immediately, no done; fresh start drains from word 0.
REQ-040 With BUF_DRAIN_HAZARD_CHK_EN: drain rows 5..7, write row 6 during row 5 -> hazard=1 and held; write row 4 -> hazard stays 0.
